// File: rtl/clock_lock_seq.sv
// clock_lock_seq
// Brings an iCE40 PLL out of power-up: holds RESETB low, waits for and
// qualifies LOCK, then releases the downstream reset. It also supervises
// loss of lock, retries a bounded number of times and latches a fault.
//
// Build option: CLOCK_LOCK_SEQ_AUTORETRY_EN
//   defined     - lock loss in RUN counts as a failed attempt and re-sequences
//   not defined - lock loss in RUN goes straight to FAULT, retries unchanged
//
// Ports:
//   clk_12m     in   board clock, all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   restart     in   single-cycle request to restart from any state
//   pll_locked  in   raw PLL LOCK, asynchronous to clk_12m
//   pll_resetb  out  PLL RESETB (low holds the PLL in reset)
//   clk_ready   out  high only in RUN
//   dn_rst      out  downstream reset, active-high, low only in RUN
//   fault       out  high only in FAULT
//   retries     out  failed attempts since reset/restart, saturating
//
// state     | meaning
// ----------+---------------------------------------------------------
// RST_PLL   | RESETB held low for RST_CYCLES cycles
// WAIT_LOCK | RESETB released, waiting up to LOCK_TIMEOUT for lock
// STABILIZE | lock seen, needs STABLE_CYCLES consecutive lock cycles
// RUN       | clock usable, downstream reset released
// FAULT     | retries exhausted (or lock lost), left only by reset/restart

`timescale 1ns/1ps

module clock_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk_12m,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       clk_ready,
    output logic       dn_rst,
    output logic       fault,
    output logic [3:0] retries
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RTY_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic [3:0]       retries_inc;
    logic             sync1_q, sync2_q;
    logic             lock_s;
    logic             fail;
    logic             pll_resetb_q, clk_ready_q, dn_rst_q, fault_q;

    assign lock_s      = sync2_q;
    assign retries_inc = (retries_q == RTY_MAX) ? retries_q : retries_q + 4'd1;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        fail      = 1'b0;

        case (state_q)
            S_RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (lock_s) begin
                    state_d = S_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STABILIZE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
`ifdef CLOCK_LOCK_SEQ_AUTORETRY_EN
                    fail = 1'b1;
`else
                    state_d = S_FAULT;
                    cnt_d   = '0;
`endif
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RST_PLL;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            retries_d = retries_inc;
            cnt_d     = '0;
            state_d   = (retries_inc == RTY_MAX) ? S_FAULT : S_RST_PLL;
        end

        if (restart) begin
            state_d   = S_RST_PLL;
            cnt_d     = '0;
            retries_d = '0;
        end
    end

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RST_PLL;
            cnt_q        <= '0;
            retries_q    <= '0;
            pll_resetb_q <= 1'b0;
            clk_ready_q  <= 1'b0;
            dn_rst_q     <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            pll_resetb_q <= (state_d != S_RST_PLL) && (state_d != S_FAULT);
            clk_ready_q  <= (state_d == S_RUN);
            dn_rst_q     <= (state_d != S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign pll_resetb = pll_resetb_q;
    assign clk_ready  = clk_ready_q;
    assign dn_rst     = dn_rst_q;
    assign fault      = fault_q;
    assign retries    = retries_q;

endmodule
